// File: rtl/registered_divider_if.sv
// Operand/result bundle for registered_divider: strobe, operands, status and signed results.
interface registered_divider_if #(
    parameter int unsigned IN_WIDTH = 10
);
    localparam int unsigned NW = 2 * IN_WIDTH;

    logic                inReady;
    logic [NW-1:0]       N;
    logic [IN_WIDTH-1:0] D;
    logic                busy;
    logic                outReady;
    logic                earlyOutReady;
    logic [NW-1:0]       Q;
    logic [IN_WIDTH-1:0] R;
    logic                divByZero;

    modport master (
        output inReady, N, D,
        input  busy, outReady, earlyOutReady, Q, R, divByZero
    );

    modport slave (
        input  inReady, N, D,
        output busy, outReady, earlyOutReady, Q, R, divByZero
    );
endinterface

// File: rtl/registered_divider.sv
// Iterative restoring signed divider, 2*IN_WIDTH-bit dividend by IN_WIDTH-bit divisor.
// Optional macro REGISTERED_DIVIDER_DIVZERO_FAST_EN: divide-by-zero skips the iteration phase.
module registered_divider #(
    parameter int unsigned IN_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    registered_divider_if.slave   bus
);
    localparam int unsigned NW = 2 * IN_WIDTH;
    localparam int unsigned CW = $clog2(NW);
    localparam int unsigned RW = IN_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [NW-1:0]       nq_q;
    logic [RW-1:0]       rem_q;
    logic [IN_WIDTH-1:0] dabs_q;
    logic                sn_q, sq_q, dz_q;
    logic                busy_q, early_q, out_q, divzero_q;
    logic [NW-1:0]       q_q;
    logic [IN_WIDTH-1:0] r_q;

    logic [NW-1:0]       n_abs_d;
    logic [IN_WIDTH-1:0] d_abs_d;
    logic [RW-1:0]       rem_shift_d, rem_d;
    logic                qbit_d;
    logic [NW-1:0]       q_fix_d;
    logic [IN_WIDTH-1:0] r_fix_d;

    // Operand magnitudes and one restoring step; nq_q shifts dividend bits out and quotient bits in.
    always_comb begin
        n_abs_d     = bus.N[NW-1] ? NW'(NW'(0) - bus.N) : bus.N;
        d_abs_d     = bus.D[IN_WIDTH-1] ? IN_WIDTH'(IN_WIDTH'(0) - bus.D) : bus.D;
        rem_shift_d = {rem_q[IN_WIDTH-1:0], nq_q[NW-1]};
        qbit_d      = (rem_shift_d >= RW'(dabs_q));
        rem_d       = qbit_d ? RW'(rem_shift_d - RW'(dabs_q)) : rem_shift_d;
    end

    // Sign fix-up with saturation for divide-by-zero and the single overflow case.
    always_comb begin
        q_fix_d = sq_q ? NW'(NW'(0) - nq_q) : nq_q;
        r_fix_d = sn_q ? IN_WIDTH'(IN_WIDTH'(0) - rem_q[IN_WIDTH-1:0]) : rem_q[IN_WIDTH-1:0];
        if (dz_q) begin
            q_fix_d = sn_q ? {1'b1, {(NW-1){1'b0}}} : {1'b0, {(NW-1){1'b1}}};
            r_fix_d = '0;
        end else if (!sq_q && nq_q[NW-1]) begin
            q_fix_d = {1'b0, {(NW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            nq_q      <= '0;
            rem_q     <= '0;
            dabs_q    <= '0;
            sn_q      <= 1'b0;
            sq_q      <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            early_q   <= 1'b0;
            out_q     <= 1'b0;
            divzero_q <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
        end else if (enable) begin
            out_q   <= early_q;
            early_q <= 1'b0;
            // busy stays up through the earlyOutReady cycle so accepts land on outReady cycles
            if (early_q) begin
                busy_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (bus.inReady && !busy_q) begin
                        nq_q    <= n_abs_d;
                        dabs_q  <= d_abs_d;
                        rem_q   <= '0;
                        sn_q    <= bus.N[NW-1];
                        sq_q    <= bus.N[NW-1] ^ bus.D[IN_WIDTH-1];
                        dz_q    <= (bus.D == '0);
                        cnt_q   <= CW'(NW - 1);
                        busy_q  <= 1'b1;
                        state_q <= CALC;
`ifdef REGISTERED_DIVIDER_DIVZERO_FAST_EN
                        if (bus.D == '0) begin
                            state_q <= FIX;
                        end
`endif
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    nq_q  <= {nq_q[NW-2:0], qbit_d};
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    q_q       <= q_fix_d;
                    r_q       <= r_fix_d;
                    divzero_q <= dz_q;
                    early_q   <= 1'b1;
                    state_q   <= IDLE;
`ifdef REGISTERED_DIVIDER_DIVZERO_FAST_EN
                    if (dz_q) begin
                        busy_q <= 1'b0;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.outReady      = out_q;
    assign bus.earlyOutReady = early_q;
    assign bus.Q             = q_q;
    assign bus.R             = r_q;
    assign bus.divByZero     = divzero_q;
endmodule

// File: tb/tb_registered_divider.sv
// Scoreboard bench for registered_divider: arithmetic reference model, randomized and directed stimulus.
module tb_registered_divider;
    localparam int unsigned IN_WIDTH = 10;
    localparam int unsigned NW       = 2 * IN_WIDTH;
    localparam longint      MAXQ     = (longint'(1) <<< (NW - 1)) - 1;
    localparam longint      MINQ     = -(longint'(1) <<< (NW - 1));

    logic clk = 1'b0;
    logic reset;
    logic enable;
    always #5 clk = ~clk;

    registered_divider_if #(.IN_WIDTH(IN_WIDTH)) bus ();

    registered_divider #(.IN_WIDTH(IN_WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    typedef struct {
        logic [NW-1:0]       q;
        logic [IN_WIDTH-1:0] r;
        logic                dz;
        int                  t;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ecount = 0;
    int   remain = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: integer division truncating toward zero, remainder follows dividend.
    function automatic exp_t model(input logic [NW-1:0] n, input logic [IN_WIDTH-1:0] d);
        longint sn, sd, q, r;
        exp_t   e;
        sn = longint'($signed(n));
        sd = longint'($signed(d));
        if (sd == 0) begin
            e.dz = 1'b1;
            q    = (sn >= 0) ? MAXQ : MINQ;
            r    = 0;
        end else begin
            e.dz = 1'b0;
            q    = sn / sd;
            r    = sn % sd;
            if (q > MAXQ) q = MAXQ;
        end
        e.q = NW'(q);
        e.r = IN_WIDTH'(r);
        e.t = 0;
        return e;
    endfunction

    // Monitor: decide accepts from driven inputs, then compare DUT outputs against the queue head.
    initial begin
        exp_t e;
        bit   exp_out, exp_early;
        int   lat, hold;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                sb.delete();
                remain = 0;
                check("rst_busy", longint'(bus.busy), 0);
                check("rst_outReady", longint'(bus.outReady), 0);
                check("rst_early", longint'(bus.earlyOutReady), 0);
                check("rst_Q", longint'(bus.Q), 0);
                check("rst_R", longint'(bus.R), 0);
                check("rst_divByZero", longint'(bus.divByZero), 0);
            end else if (enable) begin
                ecount++;
                exp_out   = (sb.size() > 0) && (sb[0].t == ecount);
                exp_early = (sb.size() > 0) && (sb[0].t == ecount + 1);
                check("outReady", longint'(bus.outReady), longint'(exp_out));
                check("earlyOutReady", longint'(bus.earlyOutReady), longint'(exp_early));
                if (exp_out) begin
                    e = sb.pop_front();
                    check("Q", longint'(bus.Q), longint'(e.q));
                    check("R", longint'(bus.R), longint'(e.r));
                    check("divByZero", longint'(bus.divByZero), longint'(e.dz));
                end
                if (remain == 0 && bus.inReady) begin
                    e    = model(bus.N, bus.D);
                    lat  = NW + 2;
                    hold = NW + 2;
`ifdef REGISTERED_DIVIDER_DIVZERO_FAST_EN
                    if (bus.D == '0) begin
                        lat  = 2;
                        hold = 1;
                    end
`endif
                    e.t    = ecount + lat;
                    remain = hold;
                    sb.push_back(e);
                end else if (remain > 0) begin
                    remain--;
                end
                check("busy", longint'(bus.busy), longint'(remain > 0));
            end
        end
    end

    task automatic op(input logic [NW-1:0] n, input logic [IN_WIDTH-1:0] d);
        @(negedge clk);
        bus.inReady = 1'b1;
        bus.N       = n;
        bus.D       = d;
        @(negedge clk);
        bus.inReady = 1'b0;
        repeat (24) @(negedge clk);
    endtask

    function automatic logic [IN_WIDTH-1:0] rand_d();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            default: return IN_WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        reset       = 1'b1;
        enable      = 1'b1;
        bus.inReady = 1'b0;
        bus.N       = '0;
        bus.D       = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        op(NW'(100), IN_WIDTH'(7));
        op(NW'(-100), IN_WIDTH'(7));
        op(NW'(100), IN_WIDTH'(-7));
        op(NW'(-100), IN_WIDTH'(-7));
        op(NW'(5), IN_WIDTH'(0));
        op(NW'(-5), IN_WIDTH'(0));
        op(NW'(-524288), IN_WIDTH'(-1));
        op(NW'(524287), IN_WIDTH'(-512));

        // inReady held high with operands changing every cycle
        @(negedge clk);
        bus.inReady = 1'b1;
        for (int i = 0; i < 75; i++) begin
            bus.N = NW'($urandom);
            bus.D = rand_d();
            @(negedge clk);
        end
        bus.inReady = 1'b0;
        repeat (25) @(negedge clk);

        // enable dropped for five cycles mid-iteration
        @(negedge clk);
        bus.inReady = 1'b1;
        bus.N       = NW'(1000);
        bus.D       = IN_WIDTH'(3);
        @(negedge clk);
        bus.inReady = 1'b0;
        repeat (8) @(negedge clk);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        repeat (25) @(negedge clk);

        // reset during iteration, then a fresh operation
        @(negedge clk);
        bus.inReady = 1'b1;
        bus.N       = NW'(12345);
        bus.D       = IN_WIDTH'(-17);
        @(negedge clk);
        bus.inReady = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        op(NW'(777), IN_WIDTH'(25));

        // random strobes, operands and enable gaps
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            bus.inReady = ($urandom_range(0, 3) == 0);
            bus.N       = NW'($urandom);
            bus.D       = rand_d();
            enable      = ($urandom_range(0, 9) != 0);
        end
        @(negedge clk);
        enable      = 1'b1;
        bus.inReady = 1'b0;
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        check("drain", longint'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
